// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, WB->ID bypass and load-use stall sequencing for the
// 5-stage pipeline, with a saturating stall-cycle performance counter.
module fwd_hazard_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_src_addr_i,
    input  logic [ADDR_W-1:0]           ex_rd_i,
    input  logic                        ex_regwrite_i,
    input  logic                        ex_memread_i,
    input  logic [ADDR_W-1:0]           mem_rd_i,
    input  logic                        mem_regwrite_i,
    input  logic [ADDR_W-1:0]           wb_rd_i,
    input  logic                        wb_regwrite_i,
    output logic [NUM_SRC*2-1:0]        ex_fwd_sel_o,
    output logic [NUM_SRC-1:0]          id_bypass_o,
    output logic                        stall_o,
    output logic                        bubble_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [CNT_W-1:0] stallCnt;
    logic             hazard;
    logic             memHit;
    logic             wbHit;
    logic             exHit;
    logic             wbLive;
    logic             memLive;

    assign memLive = mem_regwrite_i && (mem_rd_i != '0);
    assign wbLive  = wb_regwrite_i && (wb_rd_i != '0);

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        ex_fwd_sel_o = '0;
        id_bypass_o  = '0;
        memHit       = 1'b0;
        wbHit        = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            memHit = memLive && (mem_rd_i == ex_src_addr_i[k*ADDR_W +: ADDR_W]);
            wbHit  = wbLive && (wb_rd_i == ex_src_addr_i[k*ADDR_W +: ADDR_W]);
            if (memHit) begin
                ex_fwd_sel_o[k*2 +: 2] = 2'b10;
            end else if (wbHit) begin
                ex_fwd_sel_o[k*2 +: 2] = 2'b01;
            end
            id_bypass_o[k] = wbLive && (wb_rd_i == id_src_addr_i[k*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        exHit = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            exHit = exHit | (ex_rd_i == id_src_addr_i[k*ADDR_W +: ADDR_W]);
        end
        hazard = id_valid_i && ex_regwrite_i && ex_memread_i && (ex_rd_i != '0) && exHit;
    end

    // The first stall cycle is the combinational IDLE one; STALL covers the rest.
    assign stall_o     = (state == STALL) || hazard;
    assign bubble_o    = stall_o;
    assign stall_cnt_o = stallCnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            stallCnt <= '0;
        end else begin
            if (stall_o && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        cnt   <= 4'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (LOAD_LAT 1/3/4, one with a 4-bit
// counter) share stimulus and are checked each cycle against a behavioural model.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             idValid = 1'b0;
    logic [NS*AW-1:0] idSrc = '0;
    logic [NS*AW-1:0] exSrc = '0;
    logic [AW-1:0]    exRd = '0;
    logic             exRegwrite = 1'b0;
    logic             exMemread = 1'b0;
    logic [AW-1:0]    memRd = '0;
    logic             memRegwrite = 1'b0;
    logic [AW-1:0]    wbRd = '0;
    logic             wbRegwrite = 1'b0;

    logic [NS*2-1:0] fwdA [3];
    logic [NS-1:0]   bypA [3];
    logic            stallA [3];
    logic            bubA [3];
    logic [15:0]     cnt1, cnt3;
    logic [3:0]      cnt4;
    logic [31:0]     cntA [3];

    assign cntA[0] = 32'(cnt1);
    assign cntA[1] = 32'(cnt3);
    assign cntA[2] = 32'(cnt4);

    fwd_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_src_addr_i(idSrc),
        .ex_src_addr_i(exSrc), .ex_rd_i(exRd), .ex_regwrite_i(exRegwrite),
        .ex_memread_i(exMemread), .mem_rd_i(memRd), .mem_regwrite_i(memRegwrite),
        .wb_rd_i(wbRd), .wb_regwrite_i(wbRegwrite), .ex_fwd_sel_o(fwdA[0]),
        .id_bypass_o(bypA[0]), .stall_o(stallA[0]), .bubble_o(bubA[0]), .stall_cnt_o(cnt1));

    fwd_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(16)) dut3 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_src_addr_i(idSrc),
        .ex_src_addr_i(exSrc), .ex_rd_i(exRd), .ex_regwrite_i(exRegwrite),
        .ex_memread_i(exMemread), .mem_rd_i(memRd), .mem_regwrite_i(memRegwrite),
        .wb_rd_i(wbRd), .wb_regwrite_i(wbRegwrite), .ex_fwd_sel_o(fwdA[1]),
        .id_bypass_o(bypA[1]), .stall_o(stallA[1]), .bubble_o(bubA[1]), .stall_cnt_o(cnt3));

    fwd_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_src_addr_i(idSrc),
        .ex_src_addr_i(exSrc), .ex_rd_i(exRd), .ex_regwrite_i(exRegwrite),
        .ex_memread_i(exMemread), .mem_rd_i(memRd), .mem_regwrite_i(memRegwrite),
        .wb_rd_i(wbRd), .wb_regwrite_i(wbRegwrite), .ex_fwd_sel_o(fwdA[2]),
        .id_bypass_o(bypA[2]), .stall_o(stallA[2]), .bubble_o(bubA[2]), .stall_cnt_o(cnt4));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int unsigned LAT [3]    = '{1, 3, 4};
    localparam int unsigned CNTMAX [3] = '{65535, 65535, 15};
    int unsigned remM [3] = '{0, 0, 0};   // stall cycles still owed after this one
    int unsigned cntM [3] = '{0, 0, 0};

    function automatic logic [1:0] expFwd(input logic [AW-1:0] s);
        if (memRegwrite && memRd != 0 && memRd == s) return 2'b10;
        if (wbRegwrite && wbRd != 0 && wbRd == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic expHz();
        logic hit = 1'b0;
        for (int k = 0; k < NS; k++) if (idSrc[k*AW +: AW] == exRd) hit = 1'b1;
        return idValid && exRegwrite && exMemread && (exRd != 0) && hit;
    endfunction

    function automatic logic expStall(input int i);
        return (remM[i] != 0) || expHz();
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                remM[i] <= 0;
                cntM[i] <= 0;
            end else begin
                if (expStall(i) && cntM[i] < CNTMAX[i]) cntM[i] <= cntM[i] + 1;
                if (remM[i] != 0) remM[i] <= remM[i] - 1;
                else if (expHz()) remM[i] <= LAT[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NS; k++) begin
                check($sformatf("fwd[%0d][%0d]", i, k), 32'(fwdA[i][k*2 +: 2]),
                      32'(expFwd(exSrc[k*AW +: AW])));
                check($sformatf("byp[%0d][%0d]", i, k), 32'(bypA[i][k]),
                      32'(wbRegwrite && wbRd != 0 && wbRd == idSrc[k*AW +: AW]));
            end
            check($sformatf("stall[%0d]", i), 32'(stallA[i]), 32'(expStall(i)));
            check($sformatf("bubble[%0d]", i), 32'(bubA[i]), 32'(expStall(i)));
            check($sformatf("cnt[%0d]", i), cntA[i], cntM[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearIns();
        idValid = 0; idSrc = '0; exSrc = '0; exRd = '0; exRegwrite = 0; exMemread = 0;
        memRd = '0; memRegwrite = 0; wbRd = '0; wbRegwrite = 0;
    endtask

    task automatic doReset();
        rst = 1; tick(1); rst = 0;
    endtask

    task automatic setHazard(input logic [AW-1:0] r);
        exRd = r; exRegwrite = 1; exMemread = 1; idValid = 1;
        idSrc = {5'd7, r};
    endtask

    initial begin
        clearIns();
        tick(2);
        check("reset_cnt1", 32'(cnt1), 0);
        check("reset_stall1", 32'(stallA[0]), 0);
        rst = 0;

        exSrc = {5'd3, 5'd3}; memRd = 3; wbRd = 3; memRegwrite = 1; wbRegwrite = 1;
        #1 check("fwd_mem_prio", 32'(fwdA[0]), 32'h0A);
        memRegwrite = 0;
        #1 check("fwd_wb", 32'(fwdA[1]), 32'h05);
        memRd = 0; wbRd = 0; memRegwrite = 1; wbRegwrite = 1; exSrc = '0; idSrc = '0;
        #1 check("r0_fwd", 32'(fwdA[2]), 0);
        check("r0_byp", 32'(bypA[0]), 0);
        wbRd = 4; idSrc = {5'd2, 5'd4};
        #1 check("byp_op0", 32'(bypA[0]), 32'h1);
        tick(1);
        clearIns();

        doReset();
        setHazard(5);
        #1 check("lu_stall1", 32'(stallA[0]), 1);
        check("lu_bubble1", 32'(bubA[0]), 1);
        tick(1); clearIns(); tick(6);
        check("lu_cnt1", 32'(cnt1), 1);
        check("lu_cnt3", 32'(cnt3), 3);
        check("lu_cnt4", 32'(cnt4), 4);
        setHazard(5); idValid = 0;
        #1 check("novalid_stall", 32'(stallA[0]), 0);
        tick(1); clearIns(); tick(5);
        check("novalid_cnt1", 32'(cnt1), 1);
        check("novalid_cnt3", 32'(cnt3), 3);

        doReset();
        setHazard(5); tick(1); clearIns(); tick(2);
        setHazard(5); tick(1); clearIns(); tick(6);
        check("b2b_cnt3", 32'(cnt3), 6);
        check("b2b_cnt1", 32'(cnt1), 2);
        check("b2b_cnt4", 32'(cnt4), 4);

        doReset();
        setHazard(5); tick(1); clearIns();
        check("mid_pre_stall4", 32'(stallA[2]), 1);
        #1 rst = 1;
        #1 check("mid_rst_stall4", 32'(stallA[2]), 0);
        check("mid_rst_cnt4", 32'(cnt4), 0);
        tick(1); rst = 0; tick(1);
        check("mid_after_stall4", 32'(stallA[2]), 0);
        check("mid_after_cnt4", 32'(cnt4), 0);

        doReset();
        setHazard(5); tick(20);
        check("sat_cnt4", 32'(cnt4), 32'hF);
        check("sat_cnt1", 32'(cnt1), 20);
        check("sat_cnt3", 32'(cnt3), 20);
        clearIns(); tick(6);
        check("sat_hold_cnt4", 32'(cnt4), 32'hF);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            idValid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NS; k++) begin
                idSrc[k*AW +: AW] = AW'($urandom_range(0, 3));
                exSrc[k*AW +: AW] = AW'($urandom_range(0, 3));
            end
            exRd = AW'($urandom_range(0, 3));
            memRd = AW'($urandom_range(0, 3));
            wbRd = AW'($urandom_range(0, 3));
            exRegwrite = 1'($urandom_range(0, 1));
            exMemread = 1'($urandom_range(0, 1));
            memRegwrite = 1'($urandom_range(0, 1));
            wbRegwrite = 1'($urandom_range(0, 1));
            tick(1);
        end
        rst = 0; clearIns(); tick(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised operand-forwarding and load-use hazard unit for the 5-stage pipelined CPU. Generates per-operand EX forward selects (MEM over WB priority, r0 never forwarded) for NUM_SRC source operands. Generates WB->ID bypass selects. Owns the load-use stall sequencer, which holds IF/ID and injects EX bubbles for LOAD_LAT cycles, and a saturating stall-cycle performance counter.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction (1..4)
LOAD_LAT, 1, stall cycles per load-use hazard (1..15)
CNT_W, 16, stall performance counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
id_valid_i  in  1  ID holds a real instruction
id_src_addr_i  in  NUM_SRC*ADDR_W  ID source addresses; operand k at [k*ADDR_W +: ADDR_W]
ex_src_addr_i  in  NUM_SRC*ADDR_W  EX source addresses, same packing
ex_rd_i  in  ADDR_W  EX destination
ex_regwrite_i  in  1  EX writes register file
ex_memread_i  in  1  EX instruction is a load
mem_rd_i  in  ADDR_W  MEM destination
mem_regwrite_i  in  1  MEM writes register file
wb_rd_i  in  ADDR_W  WB destination
wb_regwrite_i  in  1  WB writes register file
ex_fwd_sel_o  out  NUM_SRC*2  per operand: 2'b00 regfile, 2'b10 MEM result, 2'b01 WB result, 2'b11 never driven
id_bypass_o  out  NUM_SRC  per operand: 1 = take WB write data in ID
stall_o  out  1  hold PC and IF/ID register
bubble_o  out  1  zero EX control signals next edge
stall_cnt_o  out  CNT_W  total stall cycles, saturating

Behaviour:
- Forwarding, combinational, per operand k. If mem_regwrite_i, mem_rd_i!=0 and mem_rd_i==src_k, then 2'b10. Else if wb_regwrite_i, wb_rd_i!=0 and wb_rd_i==src_k, then 2'b01. Else 2'b00. Operands are independent; identical addresses give identical selects.
- id_bypass_o[k] = wb_regwrite_i & (wb_rd_i!=0) & (wb_rd_i==id src_k). Combinational; not gated by stall.
- Hazard condition H = id_valid_i & ex_regwrite_i & ex_memread_i & (ex_rd_i!=0) & (ex_rd_i equals any id src_k).
- FSM states IDLE, STALL. Internal counter cnt, width 4.
- IDLE: stall_o = bubble_o = H, combinational. On an edge with H: if LOAD_LAT==1, stay IDLE; else go to STALL with cnt=LOAD_LAT-1.
- STALL: stall_o=1 and bubble_o=1 unconditionally; H is ignored because EX holds the bubble. Each edge decrements cnt. On the edge where cnt==1, return to IDLE. Total stall cycles per hazard = LOAD_LAT exactly.
- Back-to-back: a new H in the first IDLE cycle after STALL starts a fresh sequence with no gap.
- stall_cnt_o increments on every edge where stall_o==1 and saturates at all-ones.
- Reset, asynchronous: state=IDLE, cnt=0, stall_cnt_o=0.
- During reset, combinational outputs follow the forwarding/H equations with the FSM in IDLE.
- A reset asserted mid-STALL aborts the sequence immediately. There is no pending stall after release.
- No X propagation: all outputs are defined whenever the inputs are known.

Test Plan:
- Forward priority: ex_src={r3,r3}; mem_rd=3 and wb_rd=3, both regwrite. Expect ex_fwd_sel_o=4'b1010. Drop mem_regwrite. Expect 4'b0101.
- r0 guard: mem_rd=0, wb_rd=0, regwrite=1, ex_src={r0,r0}. Expect ex_fwd_sel_o=0 and id_bypass_o=0.
- Load-use, LOAD_LAT=1: ex load to r5, id src0=r5, id_valid=1. Expect stall_o=bubble_o=1 for exactly 1 cycle and stall_cnt_o=1. Same setup with id_valid=0: expect no stall.
- Load-use, LOAD_LAT=3: single hazard gives stall_o high exactly 3 consecutive cycles and stall_cnt_o=3. A second hazard presented on the next cycle gives 6 total.
- Reset mid-stall, LOAD_LAT=4: assert rst_i asynchronously in the 2nd stall cycle. Expect stall_o=0 and stall_cnt_o=0 before the next clock edge, and FSM IDLE after release.
- Saturation, CNT_W=4: 20 stall cycles give stall_cnt_o=4'hF and no wrap.
